// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader.
// State encoding and memory geometry constants.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          BPW      = 4;
  localparam int          DEPTH    = 32;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream from the host into the loader.
// The host is master; the loader is slave.
interface imem_loader_if;
  logic [7:0] ByteIn;
  logic       ByteValid;
  logic       ByteReady;

  modport master (
    output ByteIn,
    output ByteValid,
    input  ByteReady
  );

  modport slave (
    input  ByteIn,
    input  ByteValid,
    output ByteReady
  );
endinterface

// File: rtl/imem_word_assembler.sv
// Packs accepted bytes big-endian into 32-bit words.
// o_word_valid flags the edge that takes the last byte of a word.
module imem_word_assembler #(
  parameter int BPW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_cnt;
  logic [23:0] r_sr;
  logic        w_last;

  assign w_last       = (r_cnt == 2'(BPW - 1));
  assign o_word_valid = i_accept & w_last;
  assign o_word       = {r_sr, i_byte};

  // The shift register needs no clear at word end: the
  // next three bytes fully overwrite it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 2'd0;
      r_sr  <= 24'd0;
    end else if (i_clr) begin
      r_cnt <= 2'd0;
      r_sr  <= 24'd0;
    end else if (i_accept) begin
      r_cnt <= r_cnt + 2'd1;
      r_sr  <= {r_sr[15:0], i_byte};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Writable 32-word instruction memory with byte-stream loader.
// Fetch port reads the array combinationally at Addr[6:2].
module imem_loader #(
  parameter int AW  = 5,
  parameter int BPW = imem_pkg::BPW
) (
  input  logic          Clk,
  input  logic          Clrn,
  input  logic          Start,
  input  logic [AW:0]   WordCount,
  imem_loader_if.slave  bs,
  input  logic [31:0]   Addr,
  output logic [31:0]   Inst,
  output logic          Busy,
  output logic          Done,
  output logic          Err
);
  import imem_pkg::*;

  localparam int D = 2 ** AW;

  state_t        r_state;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_wptr;
  logic          r_busy;
  logic          r_ready;
  logic          r_done;
  logic          r_err;
  logic [31:0]   r_mem [D];

  logic          w_legal;
  logic          w_go;
  logic          w_accept;
  logic          w_wvalid;
  logic [31:0]   w_word;
  logic          w_last;
  logic          w_unused;

  assign w_legal  = (WordCount != '0) &&
                    (WordCount <= (AW+1)'(D));
  assign w_go     = Start && w_legal &&
                    (r_state != LOAD);
  assign w_accept = r_ready & bs.ByteValid;
  assign w_last   = ({1'b0, r_wptr} + 1'b1) == r_count;

  assign bs.ByteReady = r_ready;
  assign Busy         = r_busy;
  assign Done         = r_done;
  assign Err          = r_err;
  assign Inst         = r_mem[Addr[AW+1:2]];
  assign w_unused     = ^{Addr[31:AW+2], Addr[1:0]};

  imem_word_assembler #(.BPW(BPW)) u_asm (
    .clk          (Clk),
    .rst_n        (Clrn),
    .i_clr        (w_go),
    .i_accept     (w_accept),
    .i_byte       (bs.ByteIn),
    .o_word_valid (w_wvalid),
    .o_word       (w_word)
  );

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_state <= IDLE;
      r_count <= '0;
      r_wptr  <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        IDLE, DONE: begin
          if (Start && w_legal) begin
            r_count <= WordCount;
            r_wptr  <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= LOAD;
          end else if (Start) begin
            r_err <= 1'b1;
          end
        end
        LOAD: begin
          if (w_wvalid) begin
            r_wptr <= r_wptr + 1'b1;
            if (w_last) begin
              r_busy  <= 1'b0;
              r_ready <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Reset clears every word so a stale program never runs.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      for (int i = 0; i < D; i++) r_mem[i] <= NOP_WORD;
    end else if (w_wvalid) begin
      r_mem[r_wptr] <= w_word;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader.
// Reference model: expected memory image rebuilt from the byte stream.
module tb_imem_loader;

  logic        Clk = 1'b0;
  logic        Clrn = 1'b1;
  logic        Start = 1'b0;
  logic [5:0]  WordCount = '0;
  logic [31:0] Addr = '0;
  logic [31:0] Inst;
  logic        Busy;
  logic        Done;
  logic        Err;

  imem_loader_if bs ();

  imem_loader dut (
    .Clk       (Clk),
    .Clrn      (Clrn),
    .Start     (Start),
    .WordCount (WordCount),
    .bs        (bs),
    .Addr      (Addr),
    .Inst      (Inst),
    .Busy      (Busy),
    .Done      (Done),
    .Err       (Err)
  );

  always #5 Clk = ~Clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_mem [32];
  logic [31:0] wq [$];

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic read_word(int w, output logic [31:0] v);
    Addr      = $urandom;
    Addr[6:2] = w[4:0];
    #1;
    v = Inst;
  endtask

  task automatic check_all(string tag);
    logic [31:0] v;
    for (int i = 0; i < 32; i++) begin
      read_word(i, v);
      check($sformatf("%s[%0d]", tag, i), v, exp_mem[i]);
    end
  endtask

  task automatic check_status(string tag, logic b, logic d,
                              logic r);
    check({tag, "_busy"},  32'(Busy), 32'(b));
    check({tag, "_done"},  32'(Done), 32'(d));
    check({tag, "_ready"}, 32'(bs.ByteReady), 32'(r));
  endtask

  task automatic do_reset();
    Clrn         = 1'b0;
    Start        = 1'b0;
    bs.ByteValid = 1'b0;
    #2;
    check_status("in_rst", 1'b0, 1'b0, 1'b0);
    check("in_rst_err", 32'(Err), 32'd0);
    check("in_rst_inst", Inst, 32'd0);
    for (int i = 0; i < 32; i++) exp_mem[i] = 32'd0;
    tick(2);
    Clrn = 1'b1;
    tick(1);
  endtask

  task automatic do_start(int wc);
    WordCount = wc[5:0];
    Start     = 1'b1;
    tick(1);
    Start     = 1'b0;
  endtask

  task automatic push(logic [7:0] b);
    bs.ByteIn    = b;
    bs.ByteValid = 1'b1;
    check("push_ready", 32'(bs.ByteReady), 32'd1);
    tick(1);
    bs.ByteValid = 1'b0;
  endtask

  // mode 1 uses the fixed gap pattern; mode 0 random gaps.
  task automatic run_load(int mode, int max_gap);
    int          cnt;
    int          j;
    int          g;
    logic [31:0] v;
    cnt = wq.size();
    do_start(cnt);
    check_status("start", 1'b1, 1'b0, 1'b1);
    for (int w = 0; w < cnt; w++) begin
      for (int k = 0; k < 4; k++) begin
        j = 4 * w + k;
        if (mode == 1) g = (j == 2) ? 3 : (j == 4) ? 5 : 0;
        else           g = $urandom_range(max_gap, 0);
        tick(g);
        if (k == 3) begin
          read_word(w, v);
          check("partial", v, exp_mem[w]);
        end
        push(wq[w][31-8*k -: 8]);
        if (k == 3) begin
          exp_mem[w] = wq[w];
          if (w == cnt - 1) check_status("end", 1'b0, 1'b1, 1'b0);
          read_word(w, v);
          check("written", v, exp_mem[w]);
        end
      end
    end
  endtask

  task automatic illegal(int wc, logic d);
    do_start(wc);
    check("err_pulse", 32'(Err), 32'd1);
    check_status("illegal", 1'b0, d, 1'b0);
    tick(1);
    check("err_clear", 32'(Err), 32'd0);
  endtask

  initial begin
    logic [7:0]  bq [$];
    logic [31:0] v;
    bs.ByteIn    = 8'h00;
    bs.ByteValid = 1'b0;
    tick(1);

    do_reset();
    check_status("reset", 1'b0, 1'b0, 1'b0);
    check("reset_err", 32'(Err), 32'd0);
    check_all("reset");

    wq = '{32'h2001_0008, 32'h3402_000C};
    run_load(0, 0);
    check_all("two_word");

    do_reset();
    run_load(1, 0);
    check_all("gapped");

    do_reset();
    illegal(0, 1'b0);
    illegal(33, 1'b0);
    illegal(63, 1'b0);

    // Start arriving mid-load must be ignored.
    wq.delete();
    bq.delete();
    for (int i = 0; i < 3; i++) wq.push_back($urandom);
    foreach (wq[i])
      for (int k = 0; k < 4; k++) bq.push_back(wq[i][31-8*k -: 8]);
    do_start(3);
    for (int i = 0; i < 12; i++) begin
      if (i == 5) begin
        WordCount = 6'd1;
        Start     = 1'b1;
      end
      push(bq[i]);
      Start = 1'b0;
      if (i == 5) begin
        check("mid_start_err", 32'(Err), 32'd0);
        check("mid_start_busy", 32'(Busy), 32'd1);
      end
      if (i == 7) check("mid_start_done8", 32'(Done), 32'd0);
    end
    for (int i = 0; i < 3; i++) exp_mem[i] = wq[i];
    check_status("mid_start_end", 1'b0, 1'b1, 1'b0);
    check_all("mid_start");
    illegal(0, 1'b1);

    // Reset in the middle of a 4-word load.
    do_start(4);
    for (int i = 0; i < 6; i++) push(8'($urandom));
    do_reset();
    check_status("rst_mid", 1'b0, 1'b0, 1'b0);
    check_all("rst_mid");
    wq = '{32'hDEAD_BEEF};
    run_load(0, 1);
    Addr = 32'h80;
    #1;
    check("alias_80", Inst, 32'hDEAD_BEEF);

    // Random reloads; words past each count must survive.
    repeat (6) begin
      wq.delete();
      for (int i = 0; i < $urandom_range(32, 1); i++)
        wq.push_back($urandom);
      run_load(0, 2);
      check_all("rand");
    end

    wq.delete();
    for (int i = 0; i < 32; i++) wq.push_back(32'h0101_0101 * i);
    run_load(0, 0);
    check_all("full");
    bs.ByteIn    = 8'h55;
    bs.ByteValid = 1'b1;
    check("full_extra_ready", 32'(bs.ByteReady), 32'd0);
    tick(2);
    bs.ByteValid = 1'b0;
    check_status("full_after", 1'b0, 1'b1, 1'b0);
    read_word(0, v);
    check("full_keep0", v, exp_mem[0]);
    read_word(31, v);
    check("full_keep31", v, exp_mem[31]);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writable 32-word instruction memory with a byte-stream loader. It is the write side of the single-cycle CPU's instruction memory.
- A host pushes program bytes over a valid/ready stream. The block packs them big-endian into 32-bit words and writes them sequentially from word 0.
- The CPU fetch port reads the same array combinationally (word index Addr[6:2]). Busy holds the CPU off while a load is in progress.

Parameters:
- AW, 5, word-address width; depth = 2**AW = 32 words
- BPW, 4, bytes per word (fixed; not intended to be overridden)

Ports:
- Clk  in  1  rising-edge clock
- Clrn  in  1  asynchronous active-low reset
- Start  in  1  one-cycle pulse; begins a load of WordCount words from word 0
- WordCount  in  6  number of words to load, legal range 1..32; sampled only when Start is accepted
- ByteIn  in  8  program byte
- ByteValid  in  1  ByteIn is valid
- ByteReady  out  1  loader accepts a byte this cycle
- Addr  in  32  fetch byte address; only Addr[6:2] is used
- Inst  out  32  mem[Addr[6:2]], combinational
- Busy  out  1  load in progress
- Done  out  1  last load completed; sticky
- Err  out  1  one-cycle pulse on an illegal Start

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low on Clrn; no synchronous clear exists.
- Reset state while Clrn=0:
  - all 32 memory words = 32'h00000000 (nop)
  - state = IDLE; ByteReady=0, Busy=0, Done=0, Err=0
  - word pointer and byte counter = 0
  - Inst reads 0 at every address
- States: IDLE, LOAD, DONE.
- IDLE / DONE, Start=1:
  - WordCount in 1..32: latch the count, clear word pointer and byte counter, clear Done, go to LOAD next edge.
  - WordCount = 0 or > 32: Err=1 for exactly the next cycle; state and Done unchanged; memory untouched.
- LOAD:
  - Busy=1 and ByteReady=1. A byte is accepted on any edge where ByteValid=1.
  - Start is ignored in LOAD (no Err).
- Packing:
  - The first accepted byte of a word goes to bits [31:24], then [23:16], [15:8], [7:0].
  - A byte counter (0..3) advances per accepted byte and wraps 3→0.
- Write:
  - On the edge accepting the 4th byte, mem[wptr] <= {bytes0..2, ByteIn} and wptr increments.
  - The new word is visible on Inst from the cycle after that edge.
  - Partially assembled words are never written.
- Completion:
  - When the written word is the last one (wptr+1 == count), the same edge moves to DONE.
  - ByteReady=0, Busy=0, Done=1 from that cycle on.
- DONE: Done stays 1 until an accepted Start or reset. Bytes offered in IDLE/DONE are not accepted (ByteReady=0).
- Reload: a new Start in DONE overwrites words 0..count-1 only. Words beyond the new count keep their previous contents.
- Gaps: ByteValid may drop for any number of cycles mid-word or between words; the assembly state is held.
- Fetch port:
  - Always active, including during LOAD. The CPU is responsible for stalling on Busy.
  - Addr[31:7] and Addr[1:0] are ignored, so 0x80 aliases to 0x00.
- Reset mid-load: everything returns to the reset state immediately, including clearing all memory words.

Decomposition:
- Shared package imem_pkg:
  - state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2)
  - BPW=4, DEPTH=32, NOP_WORD=32'h00000000
- One sub-module imem_word_assembler: 2-bit byte counter, 24-bit shift register, word_valid/word_out outputs.
- The top level holds the FSM, the word pointer, the memory array and the read mux.

Test Plan:
- Reset: Clrn=0 then 1 → Inst=0 at Addr 0x00, 0x40 and 0x7C; Busy=0, Done=0, ByteReady=0, Err=0.
- Two-word load: Start with WordCount=2, bytes 20 01 00 08 34 02 00 0C back-to-back.
  - Addr 0x0 → 20010008 and Addr 0x4 → 3402000C.
  - Done=1 and Busy=0 in the cycle after the 8th byte.
  - Addr 0x8 still reads 0.
- Gapped stream: same 8 bytes with ByteValid low 3 cycles after byte 2 and 5 cycles after byte 4 → identical memory result. Addr 0x4 reads 0 until the 8th byte is accepted.
- Illegal Start: WordCount=0, then WordCount=33 → Err pulses for one cycle each; state stays IDLE; ByteReady stays 0.
- Start mid-load: a second Start after 5 bytes is ignored; the load completes at the original count.
- Reset mid-load: Clrn pulsed low after 6 bytes of a 4-word load → all words read 0; Busy=0; a following load of 1 word DEADBEEF reads back DEADBEEF at Addr 0x80 (alias of 0x00).
- Full load: 32 words with value = word index×0x01010101 → all 32 read back correctly; Done=1 after the 128th byte; a further ByteValid gets ByteReady=0.
